// File: rtl/req_ack_responder.sv
`default_nettype none
// ============================================================================
// Module   : req_ack_responder
// Function : Answers each req with one ack within [MIN_LAT, MAX_LAT] cycles,
//            FIFO-ordered, released on ready or forced on the deadline cycle.
// Revision : 1.0  initial release
// ============================================================================
module req_ack_responder #(
    parameter int MIN_LAT = 1,
    parameter int MAX_LAT = 3,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    input  logic                       ready,
    output logic                       ack,
    output logic                       forced,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       overflow
);

    localparam int c_AGE_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH+1);

    localparam logic [c_AGE_W-1:0] c_MIN_AGE  = c_AGE_W'(MIN_LAT-1);
    localparam logic [c_AGE_W-1:0] c_MAX_AGE  = c_AGE_W'(MAX_LAT-1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH-1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);

    generate
        if (MIN_LAT < 1 || MAX_LAT < MIN_LAT || DEPTH < MAX_LAT) begin : g_param_check
            $error("req_ack_responder: need 1 <= MIN_LAT <= MAX_LAT <= DEPTH");
        end
    endgenerate

    // Stored age is the age the entry will have at the next edge.
    logic [c_AGE_W-1:0] r_age [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_cand;
    logic [c_AGE_W-1:0] w_cand_age;
    logic               w_fire;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;

    always_comb begin
        w_empty    = (r_count == '0);
        w_full     = (r_count == c_FULL);
        w_cand     = !w_empty || req;
        w_cand_age = w_empty ? '0 : r_age[r_rd_ptr];
        w_fire     = w_cand && (w_cand_age >= c_MIN_AGE) &&
                     (ready || (w_cand_age == c_MAX_AGE));
        w_pop      = w_fire && !w_empty;
        // A bypassed request retired on its arrival edge never enters the queue.
        w_push_req = req && !(w_fire && w_empty);
        w_push     = w_push_req && !w_full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            ack      <= 1'b0;
            forced   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= r_age[i] + c_AGE_W'(1);
            end
            if (w_push) begin
                r_age[r_wr_ptr] <= c_AGE_W'(1);
                r_wr_ptr        <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            ack    <= w_fire;
            forced <= w_fire && !ready;
            if (w_push_req && w_full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign pending = r_count;

endmodule
`default_nettype wire

// File: tb/tb_req_ack_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_ack_responder
// Function : Self-checking bench: directed vector table, multi-cycle sequences
//            and randomized traffic against a request-timestamp model.
// Revision : 1.0  initial release
// ============================================================================
module tb_req_ack_responder;

    localparam int MAX_LAT = 3;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       ready;
    logic       ack0, forced0, ovf0;
    logic       ack1, forced1, ovf1;
    logic [2:0] pend0, pend1;

    always #5 clk = ~clk;

    req_ack_responder #(.MIN_LAT(1), .MAX_LAT(MAX_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .ack(ack0), .forced(forced0), .pending(pend0), .overflow(ovf0)
    );

    req_ack_responder #(.MIN_LAT(2), .MAX_LAT(MAX_LAT), .DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .ack(ack1), .forced(forced1), .pending(pend1), .overflow(ovf1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: each instance keeps the capture cycles of its stored requests.
    int caps [2][4096];
    int head [2];
    int tail [2];
    int e_ack [2];
    int e_forced [2];
    int e_ovf [2];
    int n_req [2];
    int n_ack [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input int m);
        int  minl;
        int  n;
        int  a;
        bit  cand;
        bit  fire;
        minl = (m == 0) ? 1 : 2;
        if (rst) begin
            head[m] = tail[m]; e_ack[m] = 0; e_forced[m] = 0; e_ovf[m] = 0;
            n_req[m] = 0; n_ack[m] = 0;
            return;
        end
        n    = tail[m] - head[m];
        cand = 1'b0;
        a    = 0;
        if (n > 0) begin
            cand = 1'b1;
            a    = cyc - caps[m][head[m]];
        end else if (req) begin
            cand = 1'b1;
        end
        fire        = cand && (a >= minl - 1) && (ready || a == MAX_LAT - 1);
        e_ack[m]    = fire ? 1 : 0;
        e_forced[m] = (fire && !ready) ? 1 : 0;
        if (fire) chk((m == 0) ? "latency0" : "latency1", (a + 1 >= minl && a + 1 <= MAX_LAT) ? 1 : 0, 1);
        if (fire && n > 0) head[m]++;
        if (req && !(fire && n == 0)) begin
            if (n >= DEPTH) e_ovf[m] = 1;
            else begin
                caps[m][tail[m]] = cyc;
                tail[m]++;
            end
        end
        if (req) n_req[m]++;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        if (ack0 === 1'b1) n_ack[0]++;
        if (ack1 === 1'b1) n_ack[1]++;
        chk("m_ack0", ack0, e_ack[0]);
        chk("m_forced0", forced0, e_forced[0]);
        chk("m_pend0", pend0, tail[0] - head[0]);
        chk("m_ovf0", ovf0, e_ovf[0]);
        chk("m_ack1", ack1, e_ack[1]);
        chk("m_forced1", forced1, e_forced[1]);
        chk("m_pend1", pend1, tail[1] - head[1]);
        chk("m_ovf1", ovf1, e_ovf[1]);
    endtask

    typedef struct {
        logic       rst, req, ready;
        logic       ack, forced;
        logic [2:0] pend;
    } vec_t;

    vec_t vt [$];

    task automatic add(input logic r, input logic q, input logic rd,
                       input logic a, input logic f, input logic [2:0] p);
        vec_t v;
        v.rst = r; v.req = q; v.ready = rd; v.ack = a; v.forced = f; v.pend = p;
        vt.push_back(v);
    endtask

    initial begin
        int acks;
        rst = 1'b1; req = 1'b0; ready = 1'b0;
        for (int m = 0; m < 2; m++) begin
            head[m] = 0; tail[m] = 0; e_ack[m] = 0; e_forced[m] = 0;
            e_ovf[m] = 0; n_req[m] = 0; n_ack[m] = 0;
        end

        // rst req ready | ack forced pending (default instance)
        repeat (3) add(1, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        repeat (3) add(0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        repeat (3) add(0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0);
        repeat (2) add(0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0, 0);
        repeat (9) add(0, 0, 1, 0, 0, 0);

        foreach (vt[i]) begin
            rst = vt[i].rst; req = vt[i].req; ready = vt[i].ready;
            tick();
            chk($sformatf("vec%0d_ack", i), ack0, vt[i].ack);
            chk($sformatf("vec%0d_forced", i), forced0, vt[i].forced);
            chk($sformatf("vec%0d_pend", i), pend0, vt[i].pend);
            chk($sformatf("vec%0d_ovf", i), ovf0, 0);
        end

        // Sustained requests with ready low: one forced ack per cycle after the deadline.
        acks = 0;
        for (int k = 0; k < 16; k++) begin
            rst = 1'b0; req = (k < 10); ready = 1'b0;
            tick();
            if (ack0 === 1'b1) acks++;
            chk("sus_ack", ack0, (k >= 2 && k <= 11) ? 1 : 0);
            chk("sus_forced", forced0, (k >= 2 && k <= 11) ? 1 : 0);
            chk("sus_pend", pend0, (k == 0) ? 1 : (k <= 9) ? 2 : (k == 10) ? 1 : 0);
            chk("sus_ovf", ovf0, 0);
        end
        chk("sus_ack_count", acks, 10);

        // MIN_LAT=2 instance: two back-to-back requests, never acked on arrival.
        req = 1'b0; ready = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            req = (k < 2); ready = 1'b1;
            tick();
            chk("min2_ack", ack1, (k == 1 || k == 2) ? 1 : 0);
            chk("min2_forced", forced1, 0);
            chk("min2_pend", pend1, (k <= 1) ? 1 : 0);
        end

        // Randomized traffic; counts reset so the tally covers only this phase.
        rst = 1'b1; req = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            req   = ($urandom_range(0, 99) < 60);
            ready = ($urandom_range(0, 99) < ((k < 500) ? 30 : 70));
            tick();
        end
        chk("rand_count0", n_ack[0], n_req[0] - (tail[0] - head[0]));
        chk("rand_count1", n_ack[1], n_req[1] - (tail[1] - head[1]));
        chk("rand_ovf0", ovf0, 0);
        chk("rand_ovf1", ovf1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
